// File: rtl/cphy_pkg.sv
// ============================================================
// cphy_pkg : shared C-PHY wire-state and symbol definitions
// Rev 1.0
// ============================================================
`default_nettype none

package cphy_pkg;

    // Wire-state codes: bits [2:1] select the axis, bit [0] is the sign (1 = negative)
    localparam logic [2:0] WS_PX = 3'd0;
    localparam logic [2:0] WS_NX = 3'd1;
    localparam logic [2:0] WS_PY = 3'd2;
    localparam logic [2:0] WS_NY = 3'd3;
    localparam logic [2:0] WS_PZ = 3'd4;
    localparam logic [2:0] WS_NZ = 3'd5;

    localparam logic [1:0] AX_X = 2'd0;
    localparam logic [1:0] AX_Y = 2'd1;
    localparam logic [1:0] AX_Z = 2'd2;

    // Symbol encoding {F,R,P}
    localparam logic [2:0] SYM_CCW_SAME = 3'b000;
    localparam logic [2:0] SYM_CCW_OPP  = 3'b001;
    localparam logic [2:0] SYM_CW_SAME  = 3'b010;
    localparam logic [2:0] SYM_CW_OPP   = 3'b011;
    localparam logic [2:0] SYM_FLIP     = 3'b1??;

    localparam int unsigned SYMS_PER_WORD = 7;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/cphy_symbol_serializer_if.sv
// ============================================================
// cphy_symbol_serializer_if : mapped-word handshake, mapper -> serializer
// Rev 1.0
// ============================================================
`default_nettype none

interface cphy_symbol_serializer_if;
    logic [6:0] TxFlip;
    logic [6:0] TxRotation;
    logic [6:0] TxPolarity;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output TxFlip,
        output TxRotation,
        output TxPolarity,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  TxFlip,
        input  TxRotation,
        input  TxPolarity,
        input  tx_valid,
        output tx_ready
    );
endinterface

`default_nettype wire

// File: rtl/cphy_next_state.sv
// ============================================================
// cphy_next_state : combinational trio wire-state transition for one symbol
// Rev 1.0
// ============================================================
`default_nettype none

module cphy_next_state
    import cphy_pkg::*;
#(
    parameter logic [2:0] INIT_STATE = WS_PX
) (
    input  wire logic [2:0] ws_in,
    input  wire logic       flip,
    input  wire logic       rot,
    input  wire logic       pol,
    output logic [2:0]      ws_next
);

    logic [2:0] w_sym;
    logic [1:0] w_cw;
    logic [1:0] w_ccw;

    assign w_sym = {flip, rot, pol};

    always_comb begin
        w_cw  = AX_X;
        w_ccw = AX_X;
        case (ws_in[2:1])
            AX_X:    begin w_cw = AX_Y; w_ccw = AX_Z; end
            AX_Y:    begin w_cw = AX_Z; w_ccw = AX_X; end
            AX_Z:    begin w_cw = AX_X; w_ccw = AX_Y; end
            default: begin w_cw = AX_X; w_ccw = AX_X; end
        endcase

        // Codes 6/7 are not real wire states; recover to the reset state
        ws_next = INIT_STATE;
        if (ws_in <= WS_NZ) begin
            if (w_sym ==? SYM_FLIP) begin
                ws_next = {ws_in[2:1], ~ws_in[0]};
            end else begin
                case (w_sym)
                    SYM_CW_SAME: ws_next = {w_cw,  ws_in[0]};
                    SYM_CW_OPP:  ws_next = {w_cw,  ~ws_in[0]};
                    SYM_CCW_OPP: ws_next = {w_ccw, ~ws_in[0]};
                    default:     ws_next = {w_ccw, ws_in[0]};
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cphy_symbol_serializer.sv
// ============================================================
// cphy_symbol_serializer : serializes 7 mapped symbols per word into wire states
// Rev 1.0
// ============================================================
`default_nettype none

module cphy_symbol_serializer
    import cphy_pkg::*;
#(
    parameter logic [2:0]  INIT_STATE = WS_PX,
    parameter int unsigned FIRST_IDX  = 6
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 sym_en,
    cphy_symbol_serializer_if.slave   bus,
    output logic [2:0]                wire_state,
    output logic                      sym_strobe,
    output logic [2:0]                sym_idx,
    output logic                      active,
    output logic                      underrun
);

    localparam logic [2:0] c_first_idx = 3'(FIRST_IDX);

    ser_state_t                 r_state;
    logic [2:0]                 r_cnt;
    logic [SYMS_PER_WORD-1:0]   r_flip;
    logic [SYMS_PER_WORD-1:0]   r_rot;
    logic [SYMS_PER_WORD-1:0]   r_pol;

    logic       w_last;
    logic       w_accept;
    logic [2:0] w_next;

    // Ready in the final symbol cycle lets the next word follow with no gap
    assign w_last       = (r_state == ST_ACTIVE) && (r_cnt == 3'd0) && sym_en;
    assign bus.tx_ready = (r_state == ST_IDLE) || w_last;
    assign w_accept     = bus.tx_valid && bus.tx_ready;
    assign active       = (r_state == ST_ACTIVE);

    cphy_next_state #(
        .INIT_STATE (INIT_STATE)
    ) u_next_state (
        .ws_in   (wire_state),
        .flip    (r_flip[SYMS_PER_WORD-1]),
        .rot     (r_rot[SYMS_PER_WORD-1]),
        .pol     (r_pol[SYMS_PER_WORD-1]),
        .ws_next (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_flip     <= '0;
            r_rot      <= '0;
            r_pol      <= '0;
            wire_state <= INIT_STATE;
            sym_strobe <= 1'b0;
            sym_idx    <= 3'd0;
            underrun   <= 1'b0;
        end else begin
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_flip  <= bus.TxFlip;
                        r_rot   <= bus.TxRotation;
                        r_pol   <= bus.TxPolarity;
                        r_cnt   <= c_first_idx;
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (sym_en) begin
                        wire_state <= w_next;
                        sym_strobe <= 1'b1;
                        sym_idx    <= r_cnt;
                        // MSB-first shift: the symbol at the top is always symbol r_cnt
                        r_flip     <= {r_flip[SYMS_PER_WORD-2:0], 1'b0};
                        r_rot      <= {r_rot[SYMS_PER_WORD-2:0], 1'b0};
                        r_pol      <= {r_pol[SYMS_PER_WORD-2:0], 1'b0};
                        if (r_cnt != 3'd0) begin
                            r_cnt <= r_cnt - 3'd1;
                        end else if (w_accept) begin
                            r_flip <= bus.TxFlip;
                            r_rot  <= bus.TxRotation;
                            r_pol  <= bus.TxPolarity;
                            r_cnt  <= c_first_idx;
                        end else begin
                            r_state  <= ST_IDLE;
                            underrun <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cphy_symbol_serializer.sv
// ============================================================
// tb_cphy_symbol_serializer : table, directed and randomized checks with a scoreboard
// Rev 1.0
// ============================================================
`default_nettype none

module tb_cphy_symbol_serializer;
    import cphy_pkg::*;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       sym_en = 1'b0;
    logic [2:0] wire_state;
    logic [2:0] sym_idx;
    logic       sym_strobe;
    logic       active;
    logic       underrun;

    int tests = 0;
    int fails = 0;

    cphy_symbol_serializer_if bus();

    cphy_symbol_serializer #(
        .INIT_STATE (WS_PX),
        .FIRST_IDX  (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_en     (sym_en),
        .bus        (bus),
        .wire_state (wire_state),
        .sym_strobe (sym_strobe),
        .sym_idx    (sym_idx),
        .active     (active),
        .underrun   (underrun)
    );

    logic [2:0] t_ws;
    logic       t_f;
    logic       t_r;
    logic       t_p;
    logic [2:0] t_nx;

    cphy_next_state #(
        .INIT_STATE (WS_PX)
    ) u_ns (
        .ws_in   (t_ws),
        .flip    (t_f),
        .rot     (t_r),
        .pol     (t_p),
        .ws_next (t_nx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference: a state is an (axis, sign) pair; flip negates, rotation walks x->y->z
    function automatic logic [2:0] ref_next(input logic [2:0] ws, input logic f, input logic r, input logic p);
        int axis;
        int neg;
        if (ws > 3'd5) return WS_PX;
        axis = int'(ws) / 2;
        neg  = int'(ws) % 2;
        if (f) begin
            neg = 1 - neg;
        end else begin
            axis = r ? (axis + 1) % 3 : (axis + 2) % 3;
            if (p) neg = 1 - neg;
        end
        return 3'(axis * 2 + neg);
    endfunction

    typedef struct {
        logic [2:0] ws;
        logic [2:0] idx;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] model_ws = WS_PX;
    logic [2:0] last_ws  = WS_PX;
    logic [2:0] last_idx = 3'd0;
    bit         mon_en   = 1'b0;

    // Scoreboard: outputs reflect the last edge; then record what the next edge will do
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sym_strobe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_strobe", {31'd0, sym_strobe}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_ws", {29'd0, wire_state}, {29'd0, e.ws});
                    check("sb_idx", {29'd0, sym_idx}, {29'd0, e.idx});
                    last_ws  = e.ws;
                    last_idx = e.idx;
                end
            end else begin
                check("sb_hold", {26'd0, wire_state, sym_idx}, {26'd0, last_ws, last_idx});
            end
            if (rst) begin
                exp_q.delete();
                model_ws = WS_PX;
                last_ws  = WS_PX;
                last_idx = 3'd0;
            end else if (bus.tx_valid && bus.tx_ready) begin
                for (int k = 6; k >= 0; k--) begin
                    model_ws = ref_next(model_ws, bus.TxFlip[k], bus.TxRotation[k], bus.TxPolarity[k]);
                    exp_q.push_back('{ws: model_ws, idx: 3'(k)});
                end
            end
        end
    end

    task automatic drive(input bit rs, input bit en, input bit v,
                         input logic [6:0] f, input logic [6:0] r, input logic [6:0] p);
        @(posedge clk);
        #2;
        rst            = rs;
        sym_en         = en;
        bus.tx_valid   = v;
        bus.TxFlip     = f;
        bus.TxRotation = r;
        bus.TxPolarity = p;
    endtask

    task automatic do_reset;
        drive(1, 0, 0, 7'h00, 7'h00, 7'h00);
        drive(0, 0, 0, 7'h00, 7'h00, 7'h00);
        check("rst_ws", {29'd0, wire_state}, {29'd0, WS_PX});
        check("rst_strobe", {31'd0, sym_strobe}, 32'd0);
        check("rst_idx", {29'd0, sym_idx}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_ready", {31'd0, bus.tx_ready}, 32'd1);
    endtask

    task automatic run_single(input logic [6:0] f, input logic [6:0] r, input logic [6:0] p,
                              input logic [2:0] e [7]);
        drive(0, 1, 1, f, r, p);
        check("idle_ready", {31'd0, bus.tx_ready}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 0, 7'h00, 7'h00, 7'h00);
            if (i == 0) begin
                check("accept_no_sym", {31'd0, sym_strobe}, 32'd0);
                check("accept_active", {31'd0, active}, 32'd1);
            end else begin
                check("word_ws", {29'd0, wire_state}, {29'd0, e[i-1]});
                check("word_idx", {29'd0, sym_idx}, 32'(7 - i));
            end
            check("ready_last", {31'd0, bus.tx_ready}, (i == 6) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 0, 7'h00, 7'h00, 7'h00);
        check("end_ws", {29'd0, wire_state}, {29'd0, e[6]});
        check("end_idx", {29'd0, sym_idx}, 32'd0);
        check("end_underrun", {31'd0, underrun}, 32'd1);
        check("end_active", {31'd0, active}, 32'd0);
        drive(0, 0, 0, 7'h00, 7'h00, 7'h00);
        check("after_underrun", {31'd0, underrun}, 32'd0);
        check("after_ws_hold", {29'd0, wire_state}, {29'd0, e[6]});
    endtask

    typedef struct {
        logic [2:0] ws;
        logic       f;
        logic       r;
        logic       p;
        logic [2:0] nx;
    } ns_vec_t;

    ns_vec_t    nsv [14];
    logic [2:0] b2b [14];
    logic [2:0] tog [7];

    initial begin
        int n;
        nsv[0]  = '{3'd0, 1'b1, 1'b0, 1'b0, 3'd1};
        nsv[1]  = '{3'd1, 1'b1, 1'b1, 1'b1, 3'd0};
        nsv[2]  = '{3'd5, 1'b1, 1'b0, 1'b1, 3'd4};
        nsv[3]  = '{3'd0, 1'b0, 1'b1, 1'b0, 3'd2};
        nsv[4]  = '{3'd2, 1'b0, 1'b1, 1'b0, 3'd4};
        nsv[5]  = '{3'd4, 1'b0, 1'b1, 1'b0, 3'd0};
        nsv[6]  = '{3'd0, 1'b0, 1'b0, 1'b0, 3'd4};
        nsv[7]  = '{3'd4, 1'b0, 1'b0, 1'b0, 3'd2};
        nsv[8]  = '{3'd2, 1'b0, 1'b0, 1'b0, 3'd0};
        nsv[9]  = '{3'd1, 1'b0, 1'b0, 1'b1, 3'd4};
        nsv[10] = '{3'd3, 1'b0, 1'b1, 1'b1, 3'd4};
        nsv[11] = '{3'd6, 1'b0, 1'b1, 1'b0, 3'd0};
        nsv[12] = '{3'd7, 1'b1, 1'b0, 1'b0, 3'd0};
        nsv[13] = '{3'd5, 1'b0, 1'b1, 1'b1, 3'd0};
        b2b = '{3'd4, 3'd2, 3'd0, 3'd4, 3'd2, 3'd0, 3'd4,
                3'd5, 3'd4, 3'd5, 3'd4, 3'd5, 3'd4, 3'd5};
        tog = '{3'd2, 3'd4, 3'd0, 3'd2, 3'd4, 3'd0, 3'd2};

        bus.tx_valid   = 1'b0;
        bus.TxFlip     = '0;
        bus.TxRotation = '0;
        bus.TxPolarity = '0;

        @(posedge clk);
        #2;
        mon_en = 1'b1;

        for (int i = 0; i < 14; i++) begin
            t_ws = nsv[i].ws;
            t_f  = nsv[i].f;
            t_r  = nsv[i].r;
            t_p  = nsv[i].p;
            #1;
            check($sformatf("next_state_vec%0d", i), {29'd0, t_nx}, {29'd0, nsv[i].nx});
        end

        do_reset();
        run_single(7'h7f, 7'h00, 7'h00, '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1});
        do_reset();
        run_single(7'h00, 7'h7f, 7'h00, '{3'd2, 3'd4, 3'd0, 3'd2, 3'd4, 3'd0, 3'd2});
        do_reset();
        run_single(7'h00, 7'h7f, 7'h7f, '{3'd3, 3'd4, 3'd1, 3'd2, 3'd5, 3'd0, 3'd3});

        // Back-to-back words with tx_valid held
        do_reset();
        drive(0, 1, 1, 7'h00, 7'h00, 7'h00);
        for (int i = 0; i < 14; i++) begin
            drive(0, 1, (i < 7), (i < 7) ? 7'h7f : 7'h00, 7'h00, 7'h00);
            check("b2b_ready", {31'd0, bus.tx_ready}, (i == 6 || i == 13) ? 32'd1 : 32'd0);
            check("b2b_underrun", {31'd0, underrun}, 32'd0);
            if (i == 0) begin
                check("b2b_strobe0", {31'd0, sym_strobe}, 32'd0);
            end else begin
                check("b2b_strobe", {31'd0, sym_strobe}, 32'd1);
                check("b2b_ws", {29'd0, wire_state}, {29'd0, b2b[i-1]});
            end
        end
        drive(0, 0, 0, 7'h00, 7'h00, 7'h00);
        check("b2b_end_ws", {29'd0, wire_state}, {29'd0, b2b[13]});
        check("b2b_end_underrun", {31'd0, underrun}, 32'd1);

        // sym_en alternating: 7 symbols over 14 cycles
        do_reset();
        drive(0, 1, 1, 7'h00, 7'h7f, 7'h00);
        for (int i = 0; i < 14; i++) begin
            drive(0, (i % 2 == 0), 0, 7'h00, 7'h00, 7'h00);
            n = (i + 1) / 2;
            if (i > 0) begin
                check("tog_strobe", {31'd0, sym_strobe}, ((i - 1) % 2 == 0) ? 32'd1 : 32'd0);
                check("tog_ws", {29'd0, wire_state}, {29'd0, tog[n-1]});
                check("tog_idx", {29'd0, sym_idx}, 32'(7 - n));
            end
            check("tog_active", {31'd0, active}, (i == 13) ? 32'd0 : 32'd1);
            check("tog_underrun", {31'd0, underrun}, (i == 13) ? 32'd1 : 32'd0);
        end

        // Reset mid-word, with enable and a valid word present in the reset cycle
        do_reset();
        drive(0, 1, 1, 7'h7f, 7'h00, 7'h00);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 7'h00, 7'h00, 7'h00);
        drive(1, 1, 1, 7'h7f, 7'h00, 7'h00);
        check("mid_ws_before_rst", {29'd0, wire_state}, 32'd1);
        drive(0, 0, 0, 7'h00, 7'h00, 7'h00);
        check("mid_rst_ws", {29'd0, wire_state}, 32'd0);
        check("mid_rst_active", {31'd0, active}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
        check("mid_rst_strobe", {31'd0, sym_strobe}, 32'd0);
        run_single(7'h7f, 7'h00, 7'h00, '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1});

        // Randomized traffic against the scoreboard model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), 7'($urandom), 7'($urandom), 7'($urandom));
        end
        for (int c = 0; c < 12; c++) drive(0, 1, 0, 7'h00, 7'h00, 7'h00);
        check("random_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, %0d of %0d", fails, tests);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/cphy_symbol_serializer.md
Name: cphy_symbol_serializer

Overview:
- Downstream of the 16-bit-to-7-symbol mapper on the C-PHY transmit path.
- Accepts one mapped word per handshake: 7-bit TxFlip, TxRotation and TxPolarity vectors.
- Serializes the 7 symbols, paced by a symbol-rate enable.
- Tracks the current trio wire state and emits the next wire state per symbol, for the line driver.

Parameters:
- INIT_STATE, 3'd0, wire-state code loaded on reset (+x).
- FIRST_IDX, 6, index of the first symbol transmitted (s6 first, s0 last); fixed, exposed for documentation only.

Ports:
- clk  input  1  single clock for the whole block
- rst  input  1  synchronous, active-high reset
- sym_en  input  1  symbol-rate strobe; one symbol is consumed per cycle with sym_en=1
- TxFlip  input  7  flip bit per symbol (bit i = symbol i)
- TxRotation  input  7  rotation bit per symbol
- TxPolarity  input  7  polarity bit per symbol
- tx_valid  input  1  mapped word present
- tx_ready  output  1  word accepted when tx_valid && tx_ready
- wire_state  output  3  current wire state code: 0:+x 1:-x 2:+y 3:-y 4:+z 5:-z
- sym_strobe  output  1  registered pulse: wire_state updated this cycle
- sym_idx  output  3  index of the symbol last applied (6..0)
- active  output  1  serializer holds a word in flight
- underrun  output  1  one-cycle pulse: word completed with no successor ready

Behaviour:
- Reset (synchronous, active-high): wire_state=INIT_STATE, sym_strobe=0, sym_idx=0, active=0, underrun=0. FSM goes to IDLE and shift registers clear.
- rst has priority over every other event in the same cycle, including mid-word; the partial word is discarded.
- FSM states:
  - IDLE: tx_ready=1. On accept, load the three vectors, set cnt=6, go to ACTIVE. No symbol is applied in the accept cycle.
  - ACTIVE: on each sym_en=1 cycle:
    - apply symbol cnt to produce the next wire_state; sym_strobe=1, sym_idx=cnt (visible next cycle);
    - if cnt>0, decrement cnt;
    - if cnt==0, the word is done.
- sym_en=0 in ACTIVE: hold all state; sym_strobe=0.
- tx_ready = IDLE || (ACTIVE && cnt==0 && sym_en). It is combinational from sym_en, which allows back-to-back words with no gap symbol.
- Word done with an accept in the same cycle: reload, cnt=6, stay ACTIVE.
- Word done without an accept: go to IDLE, pulse underrun, and hold wire_state at its last value.
- Symbol rule, sym = {F,R,P}:
  - F=1: same axis, opposite sign (+x<->-x); R and P are ignored.
  - F=0, R=1: clockwise axis step x->y->z->x.
  - F=0, R=0: counter-clockwise step x->z->y->x.
  - F=0, P=0: keep the sign; P=1: invert the sign.
- Illegal wire_state codes 6 and 7 are unreachable. If one is forced, the next applied symbol yields INIT_STATE.
- Latency: accept at cycle t; the first wire_state update is registered at the first sym_en cycle after t. A full word needs exactly 7 sym_en cycles.
- tx_valid deasserted while ACTIVE is not an error. underrun is asserted only at word completion.

Decomposition:
- Shared package cphy_pkg:
  - wire-state codes WS_PX..WS_NZ;
  - symbol constants SYM_CCW_SAME=3'b000, SYM_CCW_OPP=3'b001, SYM_CW_SAME=3'b010, SYM_CW_OPP=3'b011, SYM_FLIP=3'b1xx;
  - SYMS_PER_WORD=7.
- One natural sub-module: cphy_next_state, a combinational (wire_state, F, R, P) -> next wire_state. It is reused by the receive-side decoder model in the bench.

Test Plan:
- Reset, sym_en=1 every cycle, TxFlip=7'h7f, others 0, from +x -> wire_state sequence -x,+x,-x,+x,-x,+x,-x (1,0,1,0,1,0,1); sym_idx 6..0; then underrun pulse, active=0, wire_state stays 1.
- TxFlip=0, TxRotation=7'h7f, TxPolarity=0, from +x -> +y,+z,+x,+y,+z,+x,+y (2,4,0,2,4,0,2).
- TxFlip=0, TxRotation=7'h7f, TxPolarity=7'h7f -> -y,+z,-x,+y,-z,+x,-y (3,4,1,2,5,0,3).
- Two words back-to-back, tx_valid held: first word all CCW-same (000), second all flip -> 14 consecutive sym_strobe pulses.
  - First word from +x: +z,+y,+x,+z,+y,+x,+z.
  - Second word: -z,+z,-z,+z,-z,+z,-z.
  - tx_ready high exactly in the 7th sym_en cycle; no underrun between the words.
- sym_en toggling 1,0,1,0: word takes 14 cycles; wire_state and sym_idx are frozen on sym_en=0 cycles.
- rst asserted after 3 symbols of a word -> next cycle wire_state=0, active=0, tx_ready=1, no underrun pulse; the following word starts from +x.
